// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the MIPS program loader.
package mips_pkg;

  localparam int IM_AW     = 10;
  localparam int IM_BYTES  = 1024;
  localparam int MAX_WORDS = IM_BYTES / 4;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } load_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs four consecutive bytes, MSB first, into one 32-bit word.
// word is valid in the same cycle as the 4th byte (word_valid pulse).
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // Byte position counter and the three earlier bytes of the current word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      shift <= '0;
    end else if (clr) begin
      cnt   <= '0;
      shift <= '0;
    end else if (byte_valid) begin
      cnt   <= cnt + 2'd1;
      shift <= {shift[15:0], byte_data};
    end
  end

  assign word       = {shift, byte_data};
  assign word_valid = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/mips_boot_loader.sv
// Program loader: receives a framed byte stream, writes words into the
// instruction memory and releases the CPU once the checksum matches.
//
// state  | meaning
// LEN_HI | waiting for upper byte of word count
// LEN_LO | waiting for lower byte of word count
// DATA   | receiving data bytes, one IM write per 4 bytes
// CSUM   | waiting for checksum byte
// DONE   | load ok, CPU released; reload restarts
// ERR    | frame rejected; only rst leaves
module mips_boot_loader
  import mips_pkg::*;
#(
  parameter int IM_AW     = mips_pkg::IM_AW,
  parameter int MAX_WORDS = mips_pkg::MAX_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             reload,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             err
);

  localparam int WIDX_W = $clog2(MAX_WORDS + 1);

  load_state_e       state, state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       len_rx;
  logic [WIDX_W-1:0] word_idx;
  logic [7:0]        csum;
  logic              xfer;
  logic              restart;
  logic              last_word;
  logic              pack_valid;
  logic              word_valid;
  logic [31:0]       packed_word;

  assign in_ready   = !rst && (state inside {LEN_HI, LEN_LO, DATA, CSUM});
  assign xfer       = in_valid && in_ready;
  assign restart    = (state == DONE) && reload;
  assign len_rx     = {len_hi, in_data};
  assign last_word  = (word_idx == WIDX_W'(len - 16'd1));
  assign pack_valid = xfer && (state == DATA);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LEN_HI;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      LEN_HI: if (xfer) state_nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_rx > 16'(MAX_WORDS)) state_nxt = ERR;
          else if (len_rx == 16'd0)    state_nxt = CSUM;
          else                         state_nxt = DATA;
        end
      end
      DATA:   if (word_valid && last_word) state_nxt = CSUM;
      CSUM:   if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
      DONE:   if (reload) state_nxt = LEN_HI;
      ERR:    state_nxt = ERR;
      default: state_nxt = LEN_HI;
    endcase
  end

  // Length capture, word index and running XOR of every non-checksum byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi   <= '0;
      len      <= '0;
      word_idx <= '0;
      csum     <= '0;
    end else if (restart) begin
      len_hi   <= '0;
      len      <= '0;
      word_idx <= '0;
      csum     <= '0;
    end else begin
      if (xfer && state != CSUM)   csum   <= csum ^ in_data;
      if (xfer && state == LEN_HI) len_hi <= in_data;
      if (xfer && state == LEN_LO) len    <= len_rx;
      if (word_valid)              word_idx <= word_idx + 1'b1;
    end
  end

  // Registered IM write port, one strobe per completed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_we <= word_valid;
      if (word_valid) begin
        im_addr  <= IM_AW'({word_idx, 2'b00});
        im_wdata <= packed_word;
      end
    end
  end

  // Core stays in reset under system reset and anywhere outside DONE.
  assign cpu_rst = rst || (state != DONE);
  assign done    = (state == DONE);
  assign err     = (state == ERR);

endmodule

// File: tb/tb_mips_boot_loader.sv
// Scoreboard bench for the program loader.
module tb_mips_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         sb[$];
  int          errs = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [31:0] fw [8];

  mips_boot_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .reload   (reload),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every IM write must match the next expected entry, including its cycle.
  always @(negedge clk) begin
    if (!rst && im_we) begin
      if (sb.size() == 0) check("unexp_we", 1, 0);
      else begin
        wr_t e;
        e = sb.pop_front();
        check("we_addr", im_addr, e.addr);
        check("we_data", im_wdata, e.data);
        check("we_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Called at a negedge; returns at a negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit push,
                           input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    check("in_ready", in_ready, 1);
    if (push) begin
      e.addr = a; e.data = d; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input int nw, input bit bad, input int gmax);
    logic [7:0] cs;
    logic [7:0] b;
    cs = n[15:8] ^ n[7:0];
    send_byte(n[15:8], $urandom_range(gmax), 0, 0, 0);
    send_byte(n[7:0],  $urandom_range(gmax), 0, 0, 0);
    check("cpu_rst_load", cpu_rst, 1);
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = fw[i][31-8*k -: 8];
        cs = cs ^ b;
        send_byte(b, $urandom_range(gmax), k == 3, 10'(i * 4), fw[i]);
      end
    end
    check("done_pre", done, 0);
    send_byte(bad ? (cs ^ 8'h5A) : cs, $urandom_range(gmax), 0, 0, 0);
    check("sb_empty", sb.size(), 0);
    check("in_ready_end", in_ready, 0);
    if (bad) begin
      check("err", err, 1);
      check("cpu_rst_err", cpu_rst, 1);
      check("done_err", done, 0);
    end else begin
      check("done", done, 1);
      check("cpu_rst_done", cpu_rst, 0);
      check("err_ok", err, 0);
    end
  endtask

  task automatic pulse_reload(input bit expect_restart);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("rl_done", done, 0);
    check("rl_cpu_rst", cpu_rst, 1);
    check("rl_in_ready", in_ready, expect_restart);
    check("rl_err", err, !expect_restart);
  endtask

  task automatic check_reset_values();
    check("rv_in_ready", in_ready, 0);
    check("rv_cpu_rst", cpu_rst, 1);
    check("rv_done", done, 0);
    check("rv_err", err, 0);
    check("rv_im_we", im_we, 0);
    check("rv_im_addr", im_addr, 0);
    check("rv_im_wdata", im_wdata, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_rel", in_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_rel", in_ready, 1);
    @(negedge clk);

    // N=2 basic frame
    fw[0] = 32'h20080005; fw[1] = 32'h01084020;
    send_frame(16'd2, 2, 0, 0);

    // N=0 frame after reload
    pulse_reload(1);
    send_frame(16'd0, 0, 0, 0);

    // N=3 with random gaps
    pulse_reload(1);
    for (int i = 0; i < 3; i++) fw[i] = $urandom;
    send_frame(16'd3, 3, 0, 3);

    // Wrong checksum: ERR, reload ignored
    pulse_reload(1);
    fw[0] = 32'hDEADBEEF;
    send_frame(16'd1, 1, 1, 0);
    pulse_reload(0);
    repeat (3) @(negedge clk);
    check("err_hold", err, 1);
    check("cpu_rst_hold", cpu_rst, 1);
    do_reset();

    // Oversize length 257
    send_byte(8'h01, 0, 0, 0, 0);
    send_byte(8'h01, 0, 0, 0, 0);
    check("len_err", err, 1);
    check("len_in_ready", in_ready, 0);
    check("len_we", im_we, 0);
    repeat (3) @(negedge clk);
    check("len_sb", sb.size(), 0);
    do_reset();

    // Reset after 6 data bytes
    send_byte(8'h00, 0, 0, 0, 0);
    send_byte(8'h02, 0, 0, 0, 0);
    send_byte(8'hA1, 0, 0, 0, 0);
    send_byte(8'hA2, 0, 0, 0, 0);
    send_byte(8'hA3, 0, 0, 0, 0);
    send_byte(8'hA4, 0, 1, 10'h000, 32'hA1A2A3A4);
    send_byte(8'hB1, 0, 0, 0, 0);
    send_byte(8'hB2, 0, 0, 0, 0);
    check("mid_sb", sb.size(), 0);
    do_reset();
    fw[0] = 32'h11223344;
    send_frame(16'd1, 1, 0, 0);

    // Reload and rewrite word 0
    pulse_reload(1);
    fw[0] = 32'hCAFEF00D;
    send_frame(16'd1, 1, 0, 1);

    repeat (5) @(negedge clk);
    check("final_sb", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
